// File: rtl/pwr_ctrl_pkg.sv
// Shared power-controller definitions: PI sequencer states, ADC channel IDs
// and default datapath widths.
package pwr_ctrl_pkg;

  localparam int DEF_ERR_W  = 13;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_FRAC   = 6;

  localparam logic [1:0] CH_VOUT = 2'b00;
  localparam logic [1:0] CH_TEMP = 2'b01;
  localparam logic [1:0] CH_VIN  = 2'b10;
  localparam logic [1:0] CH_IOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_P = 3'd1,
    MUL_I = 3'd2,
    SUM   = 3'd3,
    CLAMP = 3'd4,
    OUT   = 3'd5
  } pi_state_t;

endpackage

// File: rtl/pi_compensator_if.sv
// Sample-in / duty-out bundle between the ADC read stage, the PI compensator
// and the DPWM stage.
interface pi_compensator_if
  import pwr_ctrl_pkg::*;
#(
  parameter int ERR_W  = DEF_ERR_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int DUTY_W = 10
);
  logic                    SAMPLE_VALID;
  logic [1:0]              CH_ID;
  logic signed [ERR_W-1:0] ERR_DATA;
  logic [COEF_W-1:0]       KP;
  logic [COEF_W-1:0]       KI;
  logic [DUTY_W-1:0]       DUTY;
  logic                    DUTY_VALID;
  logic                    BUSY;
  logic                    SAT;
  logic                    OVERRUN;

  modport master (
    output SAMPLE_VALID, CH_ID, ERR_DATA, KP, KI,
    input  DUTY, DUTY_VALID, BUSY, SAT, OVERRUN
  );

  modport slave (
    input  SAMPLE_VALID, CH_ID, ERR_DATA, KP, KI,
    output DUTY, DUTY_VALID, BUSY, SAT, OVERRUN
  );
endinterface

// File: rtl/pi_compensator_sat_clamp.sv
// sat_clamp: signed range clamp [lo, hi] narrowed to OUT_W bits, with
// above/below/saturated flags. Limits are ports so they may be dynamic.
module sat_clamp #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0] din,
  input  logic signed [IN_W-1:0] lo,
  input  logic signed [IN_W-1:0] hi,
  output logic [OUT_W-1:0]       dout,
  output logic                   above,
  output logic                   below,
  output logic                   sat
);
  logic signed [IN_W-1:0] clamped;

  always_comb begin
    above   = din > hi;
    below   = din < lo;
    sat     = above | below;
    clamped = above ? hi : (below ? lo : din);
    dout    = OUT_W'(clamped);
  end
endmodule

// File: rtl/pi_compensator.sv
// PI compensator for the regulated ADC channel: one shared multiplier,
// saturating integrator with anti-windup, clamped duty word for the DPWM.
// Optional build macro: PI_SOFTSTART_EN (ramped upper duty clamp).
module pi_compensator
  import pwr_ctrl_pkg::*;
#(
  parameter int         ERR_W     = DEF_ERR_W,
  parameter int         COEF_W    = DEF_COEF_W,
  parameter int         FRAC      = DEF_FRAC,
  parameter int         ACC_W     = 24,
  parameter int         DUTY_W    = 10,
  parameter int         DUTY_MIN  = 0,
  parameter int         DUTY_MAX  = 900,
  parameter int         DUTY_INIT = 0,
  parameter logic [1:0] CTRL_CH   = CH_VOUT
) (
  input logic               CLK,
  input logic               RSTp,
  pi_compensator_if.slave   bus
);
  localparam int P_W = ERR_W + COEF_W + 1;
  // p + cand is formed one bit wider than the integrator so it cannot wrap
  localparam int S_W = ACC_W + 1;
  localparam logic signed [S_W-1:0] ACC_HI = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] ACC_LO = {2'b11, {(ACC_W-1){1'b0}}};

  pi_state_t state, state_nxt;
  logic      busy, ctrl_hit;

  logic signed [ERR_W-1:0] e_q;
  logic [COEF_W-1:0]       kp_q, ki_q, mul_coef;
  logic signed [P_W-1:0]   prod, p_q;
  logic signed [ACC_W-1:0] integ, cand_q;
  logic [ACC_W-1:0]        cand_sat;
  logic signed [S_W-1:0]   acc_sum, sum_ext, s_q;
  logic signed [S_W-1:0]   duty_lo, duty_hi;
  logic [DUTY_W-1:0]       duty_clamped, duty_c, duty_q;
  logic                    d_above, d_below, d_sat, sat_c, sat_q;
  logic                    dv_q, overrun_q, hold, e_pos, e_neg;
  logic [2:0]              isat_unused;

  assign ctrl_hit = bus.SAMPLE_VALID && (bus.CH_ID == CTRL_CH);

  always_ff @(posedge CLK or posedge RSTp)
    if (RSTp) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (ctrl_hit) state_nxt = MUL_P;
      end
      MUL_P:   state_nxt = MUL_I;
      MUL_I:   state_nxt = SUM;
      SUM:     state_nxt = CLAMP;
      CLAMP:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single multiplier: KP in MUL_P, KI in MUL_I (gains are unsigned)
  assign mul_coef = (state == MUL_I) ? ki_q : kp_q;
  assign prod     = P_W'($signed({1'b0, mul_coef})) * P_W'(e_q);

  assign acc_sum = S_W'(integ) + S_W'(prod);
  sat_clamp #(.IN_W(S_W), .OUT_W(ACC_W)) u_integ_sat (
    .din(acc_sum), .lo(ACC_LO), .hi(ACC_HI), .dout(cand_sat),
    .above(isat_unused[0]), .below(isat_unused[1]), .sat(isat_unused[2])
  );

  assign sum_ext = S_W'(p_q) + S_W'(cand_q);
  assign duty_lo = S_W'(DUTY_MIN);

`ifdef PI_SOFTSTART_EN
  logic [DUTY_W-1:0] ramp, ramp_lim;
  // Ceiling for the result being computed sits one step above the last one issued
  assign ramp_lim = (ramp < DUTY_W'(DUTY_MAX)) ? ramp + DUTY_W'(1) : DUTY_W'(DUTY_MAX);
  assign duty_hi  = S_W'(ramp_lim);

  always_ff @(posedge CLK or posedge RSTp)
    if (RSTp)                                            ramp <= DUTY_W'(DUTY_MIN);
    else if (state == OUT && ramp < DUTY_W'(DUTY_MAX))   ramp <= ramp + DUTY_W'(1);
`else
  assign duty_hi = S_W'(DUTY_MAX);
`endif

  sat_clamp #(.IN_W(S_W), .OUT_W(DUTY_W)) u_duty_clamp (
    .din(s_q), .lo(duty_lo), .hi(duty_hi), .dout(duty_clamped),
    .above(d_above), .below(d_below), .sat(d_sat)
  );

  // Freeze the integrator when the error would push further into the rail
  assign e_neg = e_q[ERR_W-1];
  assign e_pos = !e_q[ERR_W-1] && (|e_q);
  assign hold  = (d_above && e_pos) || (d_below && e_neg);

  always_ff @(posedge CLK or posedge RSTp) begin
    if (RSTp) begin
      e_q       <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      p_q       <= '0;
      cand_q    <= '0;
      s_q       <= '0;
      integ     <= '0;
      duty_c    <= '0;
      sat_c     <= 1'b0;
      duty_q    <= DUTY_W'(DUTY_INIT);
      sat_q     <= 1'b0;
      dv_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (ctrl_hit && state != IDLE) overrun_q <= 1'b1;
      unique case (state)
        IDLE: if (ctrl_hit) begin
          e_q  <= bus.ERR_DATA;
          kp_q <= bus.KP;
          ki_q <= bus.KI;
        end
        MUL_P: p_q    <= prod;
        MUL_I: cand_q <= $signed(cand_sat);
        SUM:   s_q    <= sum_ext >>> FRAC;
        CLAMP: begin
          duty_c <= duty_clamped;
          sat_c  <= d_sat;
          if (!hold) integ <= cand_q;
        end
        OUT: begin
          duty_q <= duty_c;
          sat_q  <= sat_c;
          dv_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.DUTY       = duty_q;
  assign bus.DUTY_VALID = dv_q;
  assign bus.BUSY       = busy;
  assign bus.SAT        = sat_q;
  assign bus.OVERRUN    = overrun_q;
endmodule

// File: tb/tb_pi_compensator.sv
// Bench for pi_compensator: vector table, hand sequences for reset/overrun,
// and randomized samples against an arithmetic PI model.
module tb_pi_compensator;
  import pwr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  pi_compensator_if bus ();

  pi_compensator dut (.CLK(clk), .RSTp(rst), .bus(bus));

  always #25 clk = ~clk;

  // Reference state: integrator value and count of issued updates
  longint m_integ;
  int     m_nupd;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_integ = 0;
    m_nupd  = 0;
  endtask

  task automatic model_step(input int e, input int kp, input int ki,
                            output int duty, output bit sat);
    longint p, cand, s, hi;
    p    = longint'(kp) * e;
    cand = m_integ + longint'(ki) * e;
    if (cand > 64'sd8388607)  cand = 64'sd8388607;
    if (cand < -64'sd8388608) cand = -64'sd8388608;
    s = (p + cand) >>> 6;
`ifdef PI_SOFTSTART_EN
    hi = (m_nupd + 1 < 900) ? m_nupd + 1 : 900;
`else
    hi = 900;
`endif
    if (s > hi)     begin duty = int'(hi); sat = 1'b1; end
    else if (s < 0) begin duty = 0;        sat = 1'b1; end
    else            begin duty = int'(s);  sat = 1'b0; end
    if (!((s > hi && e > 0) || (s < 0 && e < 0))) m_integ = cand;
    m_nupd++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.SAMPLE_VALID = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one sample and return cycles from the accept edge to DUTY_VALID
  task automatic run_sample(input logic [1:0] ch, input int e, input int kp,
                            input int ki, output int lat);
    @(negedge clk);
    bus.SAMPLE_VALID = 1'b1;
    bus.CH_ID    = ch;
    bus.ERR_DATA = 13'(e);
    bus.KP       = 8'(kp);
    bus.KI       = 8'(ki);
    @(negedge clk);
    bus.SAMPLE_VALID = 1'b0;
    lat = -1;
    for (int j = 0; j < 12; j++) begin
      if (bus.DUTY_VALID) begin lat = j; break; end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      chk("dv_single_pulse", bus.DUTY_VALID, 0);
    end
  endtask

  typedef struct {
    bit rst_first;
    int kp;
    int ki;
    int e;
    int duty;
    bit sat;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int   lat, exp_duty, seen;
    bit   exp_sat;

    vecs[0] = '{1, 64,  0,   100, 100, 0};
    vecs[1] = '{1,  0, 64,    10,  10, 0};
    vecs[2] = '{0,  0, 64,    10,  20, 0};
    vecs[3] = '{0,  0, 64,    10,  30, 0};
    vecs[4] = '{0,  0, 64,   -35,   0, 1};
    vecs[5] = '{1, 64,  0,  2000, 900, 1};
    vecs[6] = '{0, 64,  0,   -50,   0, 1};
    vecs[7] = '{1,  0, 64,   500, 500, 0};
    vecs[8] = '{0,  0, 64,   500, 900, 1};
    vecs[9] = '{0,  0, 64,  -100, 400, 0};

    bus.SAMPLE_VALID = 1'b1;
    bus.CH_ID    = CH_VOUT;
    bus.ERR_DATA = 13'sd100;
    bus.KP       = 8'd64;
    bus.KI       = 8'd0;
    model_reset();

    // Reset held with a live sample: nothing is accepted
    repeat (3) @(negedge clk);
    chk("rst_duty", bus.DUTY, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_dv", bus.DUTY_VALID, 0);
    chk("rst_sat", bus.SAT, 0);
    chk("rst_overrun", bus.OVERRUN, 0);
    bus.SAMPLE_VALID = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", bus.BUSY, 0);

    // Reset during MUL_I aborts the update and leaves the integrator at 0
    bus.SAMPLE_VALID = 1'b1;
    bus.CH_ID = CH_VOUT; bus.ERR_DATA = 13'sd100; bus.KP = 8'd0; bus.KI = 8'd64;
    @(negedge clk);
    bus.SAMPLE_VALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.BUSY, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.DUTY_VALID) seen++;
    end
    chk("abort_no_dv", seen, 0);
    model_reset();
    run_sample(CH_VOUT, 1, 0, 64, lat);
    model_step(1, 0, 64, exp_duty, exp_sat);
    chk("abort_integ_zero", bus.DUTY, exp_duty);

`ifndef PI_SOFTSTART_EN
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_sample(CH_VOUT, vecs[i].e, vecs[i].kp, vecs[i].ki, lat);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_duty", i), bus.DUTY, vecs[i].duty);
      chk($sformatf("vec%0d_sat", i), bus.SAT, vecs[i].sat);
    end
`else
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      run_sample(CH_VOUT, 500, 64, 0, lat);
      chk($sformatf("soft%0d_duty", i), bus.DUTY, i);
      chk($sformatf("soft%0d_sat", i), bus.SAT, 1);
    end
`endif

    // Foreign channel ignored; CTRL_CH sample during BUSY dropped and sticky
    do_reset();
    @(negedge clk);
    bus.SAMPLE_VALID = 1'b1; bus.CH_ID = CH_TEMP;
    @(negedge clk);
    bus.SAMPLE_VALID = 1'b0;
    chk("other_ch_busy", bus.BUSY, 0);
    bus.SAMPLE_VALID = 1'b1;
    bus.CH_ID = CH_VOUT; bus.ERR_DATA = 13'sd77; bus.KP = 8'd64; bus.KI = 8'd0;
    @(negedge clk);
    bus.CH_ID = CH_TEMP; bus.ERR_DATA = 13'sd5;
    @(negedge clk);
    chk("ovr_other_ch", bus.OVERRUN, 0);
    bus.CH_ID = CH_VOUT;
    @(negedge clk);
    bus.SAMPLE_VALID = 1'b0;
    chk("ovr_set", bus.OVERRUN, 1);
    lat = -1;
    for (int j = 0; j < 10; j++) begin
      if (bus.DUTY_VALID) begin lat = j; break; end
      @(negedge clk);
    end
    chk("ovr_dv_seen", lat >= 0, 1);
    model_step(77, 64, 0, exp_duty, exp_sat);
    chk("ovr_duty", bus.DUTY, exp_duty);
    repeat (8) @(negedge clk);
    chk("ovr_dropped_idle", bus.BUSY, 0);
    chk("ovr_sticky", bus.OVERRUN, 1);
    do_reset();
    chk("ovr_cleared", bus.OVERRUN, 0);

    // Randomized samples against the model
    for (int i = 0; i < 60; i++) begin
      int ch, e, kp, ki;
      ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      e  = (i % 4 == 0) ? int'($urandom_range(0, 8191)) - 4096
                        : int'($urandom_range(0, 1600)) - 800;
      kp = (i % 5 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 100));
      ki = (i % 7 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 100));
      if (ch != 0) begin
        @(negedge clk);
        bus.SAMPLE_VALID = 1'b1; bus.CH_ID = 2'(ch); bus.ERR_DATA = 13'(e);
        @(negedge clk);
        bus.SAMPLE_VALID = 1'b0;
        chk($sformatf("rnd%0d_ignored", i), bus.BUSY, 0);
      end else begin
        run_sample(CH_VOUT, e, kp, ki, lat);
        model_step(e, kp, ki, exp_duty, exp_sat);
        chk($sformatf("rnd%0d_latency", i), lat, 5);
        chk($sformatf("rnd%0d_duty", i), bus.DUTY, exp_duty);
        chk($sformatf("rnd%0d_sat", i), bus.SAT, exp_sat);
      end
    end
    chk("rnd_no_overrun", bus.OVERRUN, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
